// File: rtl/key_num_entry.sv
// Pushbutton numeric entry: synchronizes and debounces four active-low keys and turns
// their press events into a held, handshaked 8-bit signed value with overrun tracking.
module key_num_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        SW,
  input  logic [3:0]        KEY,
  output logic signed [7:0] num,
  output logic              num_valid,
  input  logic              num_ready,
  output logic              overrun,
  output logic              sat
);

  localparam int unsigned NK = 4;
  localparam int unsigned CW = 20;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [NK-1:0] sync1;
  logic [NK-1:0] sync2;
  logic [NK-1:0] press;
  logic [1:0]    flush;

  // Two-flop synchronizer; flush marks when sync2 reflects real pin levels after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
      flush <= '0;
    end else begin
      sync1 <= KEY;
      sync2 <= sync1;
      flush <= {flush[0], 1'b1};
    end
  end

  for (genvar k = 0; k < NK; k++) begin : g_key
    logic [CW-1:0] cnt_q;
    logic          db_q;
    logic          armed_q;
    logic          press_q;
    logic          last_q;
    logic          counting;

    // A key is armed only after it has been seen released (stably) since reset,
    // so a key held through reset cannot produce a press.
    always_comb begin
      counting = (sync2[k] != db_q) || (flush[1] && !armed_q && sync2[k] && db_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q   <= '0;
        db_q    <= 1'b1;
        armed_q <= 1'b0;
        press_q <= 1'b0;
        last_q  <= 1'b1;
      end else begin
        press_q <= 1'b0;
        last_q  <= sync2[k];
        if (!counting) begin
          cnt_q <= '0;
        end else if (sync2[k] != last_q) begin
          cnt_q <= CW'(1);
        end else if (cnt_q == CNT_MAX) begin
          cnt_q <= '0;
          db_q  <= sync2[k];
          if (sync2[k]) armed_q <= 1'b1;
          else          press_q <= armed_q;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end

    assign press[k] = press_q;
  end

  logic              negate;
  logic              load;
  logic              load_sat;
  logic signed [7:0] load_val;

  // CANCEL (press[2]) outranks NEGATE, which outranks ENTER.
  always_comb begin
    negate   = press[1];
    load     = press[1] | press[0];
    load_sat = 1'b0;
    load_val = SW;
    if (negate) begin
      if (SW == 8'h80) begin
        load_val = 8'h7F;
        load_sat = 1'b1;
      end else begin
        load_val = 8'd0 - SW;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num       <= '0;
      num_valid <= 1'b0;
      overrun   <= 1'b0;
      sat       <= 1'b0;
    end else begin
      if (press[3]) overrun <= 1'b0;
      if (press[2]) begin
        num_valid <= 1'b0;
        num       <= '0;
        sat       <= 1'b0;
      end else if (load) begin
        if (!num_valid || num_ready) begin
          num       <= load_val;
          sat       <= load_sat;
          num_valid <= 1'b1;
        end else begin
          overrun   <= 1'b1;
        end
      end else if (num_valid && num_ready) begin
        num_valid <= 1'b0;
      end
    end
  end

endmodule
